// File: rtl/memcore_pkg.sv
// Shared sizing helpers and constants for the BRAM-backed stream FIFO controller.
package memcore_pkg;

  localparam int OUT_DEPTH = 2;

  // Bits needed to hold a count in 0..range inclusive.
  function automatic int cnt_width(input int range);
    return $clog2(range + 1);
  endfunction

  // Pointer increment for depths that need not be a power of two.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned range);
    return (ptr == range - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/memcore_bram_fifo_ctrl_if.sv
// Stream-side FIFO handshake plus the simple-dual-port memory core connection.
interface memcore_bram_fifo_ctrl_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]    if_din;
  logic                     if_write;
  logic                     if_full_n;
  logic [DATA_WIDTH-1:0]    if_dout;
  logic                     if_read;
  logic                     if_empty_n;
  logic [ADDRESS_WIDTH-1:0] mem_address0;
  logic                     mem_ce0;
  logic                     mem_we0;
  logic [DATA_WIDTH-1:0]    mem_d0;
  logic [ADDRESS_WIDTH-1:0] mem_address1;
  logic                     mem_ce1;
  logic [DATA_WIDTH-1:0]    mem_q1;

  modport slave (
    input  if_din, if_write, if_read, mem_q1,
    output if_full_n, if_dout, if_empty_n,
           mem_address0, mem_ce0, mem_we0, mem_d0, mem_address1, mem_ce1
  );

  modport master (
    output if_din, if_write, if_read, mem_q1,
    input  if_full_n, if_dout, if_empty_n,
           mem_address0, mem_ce0, mem_we0, mem_d0, mem_address1, mem_ce1
  );
endinterface

// File: rtl/memcore_bram_fifo_out_buf.sv
// Head/skid output register pair that absorbs the one-cycle BRAM read latency.
module memcore_bram_fifo_out_buf
  import memcore_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = cnt_width(OUT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty_n,
  output logic                  pop,
  output logic [CNT_W-1:0]      out_cnt
);

  logic [DATA_WIDTH-1:0] head, skid;
  logic [CNT_W-1:0]      cnt, cnt_left;

  assign pop      = read && (cnt != '0);
  assign cnt_left = cnt - CNT_W'(pop);
  assign dout     = head;
  assign empty_n  = (cnt != '0);
  assign out_cnt  = cnt;

  // A capture lands in whichever slot is the oldest free one after the pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      skid <= '0;
      cnt  <= '0;
    end else begin
      if (pop) head <= skid;
      if (capture) begin
        if (cnt_left == '0) head <= cap_data;
        else                skid <= cap_data;
      end
      cnt <= cnt_left + CNT_W'(capture);
    end
  end

endmodule

// File: rtl/memcore_bram_fifo_ctrl.sv
// First-word-fall-through FIFO built on a simple-dual-port BRAM core with 1-cycle read latency.
module memcore_bram_fifo_ctrl
  import memcore_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6,
  parameter int ADDRESS_RANGE = 64
) (
  input logic                  clk,
  input logic                  reset,
  memcore_bram_fifo_ctrl_if.slave bus
);

  localparam int CW  = cnt_width(ADDRESS_RANGE);
  localparam int OW  = cnt_width(OUT_DEPTH);
  localparam int OCW = OW + 1;

  logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]            mem_cnt;
  logic                     inflight;
  logic [OW-1:0]            out_cnt;
  logic                     wr, pop, rd_issue;
  logic [OCW-1:0]           occ;

  assign bus.if_full_n = (mem_cnt < CW'(ADDRESS_RANGE));
  assign wr            = bus.if_write && bus.if_full_n;

  // Words already committed to the output side once this cycle's pop retires.
  assign occ      = OCW'(out_cnt) + OCW'(inflight) - OCW'(pop);
  assign rd_issue = (mem_cnt != '0) && (occ < OCW'(OUT_DEPTH));

  assign bus.mem_address0 = wr_ptr;
  assign bus.mem_ce0      = wr;
  assign bus.mem_we0      = wr;
  assign bus.mem_d0       = bus.if_din;
  assign bus.mem_address1 = rd_ptr;
  assign bus.mem_ce1      = rd_issue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (wr)       wr_ptr <= ADDRESS_WIDTH'(ptr_next(32'(wr_ptr), ADDRESS_RANGE));
      if (rd_issue) rd_ptr <= ADDRESS_WIDTH'(ptr_next(32'(rd_ptr), ADDRESS_RANGE));
      mem_cnt  <= mem_cnt + CW'(wr) - CW'(rd_issue);
      inflight <= rd_issue;
    end
  end

  memcore_bram_fifo_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
    .clk     (clk),
    .reset   (reset),
    .capture (inflight),
    .cap_data(bus.mem_q1),
    .read    (bus.if_read),
    .dout    (bus.if_dout),
    .empty_n (bus.if_empty_n),
    .pop     (pop),
    .out_cnt (out_cnt)
  );

endmodule

// File: tb/tb_memcore_bram_fifo_ctrl.sv
// Two controllers (depth 64 and depth 5) share one stimulus stream; each is scored against a queue model.
module tb_memcore_bram_fifo_ctrl;
  localparam int AR0 = 64;
  localparam int AR1 = 5;

  typedef struct { int cyc; int k; int sig; bit val; } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, write = 1'b0, read = 1'b0;
  logic [31:0] din = '0;
  logic [1:0]  full_n, empty_n, ce0, we0, ce1;
  logic [31:0] dout [2];
  logic [31:0] d0 [2];
  logic [5:0]  a0 [2];
  logic [5:0]  a1 [2];

  logic [31:0] sbq [2][$];
  exp_t        eq [$];
  int          cyc = 0, n_chk = 0, n_pass = 0;
  int          wcnt [2], icnt [2], pcnt [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int AR = (g == 0) ? AR0 : AR1;
    localparam int AW = (g == 0) ? 6 : 3;
    memcore_bram_fifo_ctrl_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(AW)) bus ();
    logic [31:0] mem [2**AW];

    memcore_bram_fifo_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(AW), .ADDRESS_RANGE(AR)) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus.slave)
    );

    assign bus.if_din   = din;
    assign bus.if_write = write;
    assign bus.if_read  = read;

    always @(posedge clk) begin
      if (bus.mem_ce0 && bus.mem_we0) mem[bus.mem_address0] <= bus.mem_d0;
      if (bus.mem_ce1) bus.mem_q1 <= mem[bus.mem_address1];
    end

    assign full_n[g]  = bus.if_full_n;
    assign empty_n[g] = bus.if_empty_n;
    assign ce0[g]     = bus.mem_ce0;
    assign we0[g]     = bus.mem_we0;
    assign ce1[g]     = bus.mem_ce1;
    assign dout[g]    = bus.if_dout;
    assign d0[g]      = bus.mem_d0;
    assign a0[g]      = 6'(bus.mem_address0);
    assign a1[g]      = 6'(bus.mem_address1);
  end

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", nm, k, cyc, act, exp);
  endtask

  // Drive one cycle of stimulus; accepted words go straight into the scoreboard.
  task automatic drive(input bit w, input bit r, input logic [31:0] d);
    @(posedge clk);
    #1;
    write = w;
    read  = r;
    din   = d;
    for (int k = 0; k < 2; k++)
      if (w && rst_n && full_n[k]) sbq[k].push_back(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0);
  endtask

  // sig: 0 = if_empty_n, 1 = if_full_n, 2 = mem_ce1; off counts cycles after the one just driven.
  task automatic expect_at(input int off, input int k, input int sig, input bit val);
    eq.push_back('{cyc + 1 + off, k, sig, val});
  endtask

  always @(negedge clk) begin : mon
    int ar, tot, bram, occ;
    bit wa, pp;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      ar = (k == 0) ? AR0 : AR1;
      if (!rst_n) begin
        check("rst_empty_n", k, 32'(empty_n[k]), 32'h0);
        check("rst_full_n",  k, 32'(full_n[k]),  32'h1);
        check("rst_ce0",     k, 32'(ce0[k]),     32'h0);
        check("rst_ce1",     k, 32'(ce1[k]),     32'h0);
        check("rst_dout",    k, dout[k],         32'h0);
        sbq[k].delete();
        wcnt[k] = 0;
        icnt[k] = 0;
        pcnt[k] = 0;
      end else begin
        wa   = write && full_n[k];
        pp   = read && empty_n[k];
        tot  = sbq[k].size() - int'(wa);
        bram = wcnt[k] - icnt[k];
        occ  = icnt[k] - pcnt[k];
        if (tot < ar)      check("full_n_room", k, 32'(full_n[k]), 32'h1);
        if (tot >= ar + 2) check("full_n_full", k, 32'(full_n[k]), 32'h0);
        check("ce0_we0", k, {30'b0, ce0[k], we0[k]}, {30'b0, wa, wa});
        if (wa) begin
          check("addr0", k, 32'(a0[k]), 32'(wcnt[k] % ar));
          check("d0", k, d0[k], din);
        end
        check("ce1", k, 32'(ce1[k]), 32'((bram > 0) && (occ - int'(pp) < 2)));
        if (ce1[k]) check("addr1", k, 32'(a1[k]), 32'(icnt[k] % ar));
        if (pp) begin
          check("pop_has_word", k, 32'(tot > 0), 32'h1);
          if (tot > 0) check("dout", k, dout[k], sbq[k].pop_front());
        end
        if (wa)     wcnt[k]++;
        if (ce1[k]) icnt[k]++;
        if (pp)     pcnt[k]++;
        check("bram_le_range", k, 32'((wcnt[k] - icnt[k]) <= ar), 32'h1);
      end
    end
    foreach (eq[i]) begin
      if (eq[i].cyc == cyc) begin
        case (eq[i].sig)
          0:       check("exp_empty_n", eq[i].k, 32'(empty_n[eq[i].k]), 32'(eq[i].val));
          1:       check("exp_full_n",  eq[i].k, 32'(full_n[eq[i].k]),  32'(eq[i].val));
          default: check("exp_ce1",     eq[i].k, 32'(ce1[eq[i].k]),     32'(eq[i].val));
        endcase
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Single write into an empty FIFO: read issue next cycle, head valid three cycles later.
    drive(1'b1, 1'b0, 32'hA5);
    for (int k = 0; k < 2; k++) begin
      expect_at(0, k, 0, 1'b0);
      expect_at(1, k, 2, 1'b1);
      expect_at(2, k, 0, 1'b0);
      expect_at(3, k, 0, 1'b1);
    end
    idle(4);
    drive(1'b0, 1'b1, 32'h0);
    idle(3);
    for (int k = 0; k < 2; k++) expect_at(0, k, 0, 1'b0);

    // Fill past capacity with no reads, then drain.
    for (int i = 0; i < 67; i++) drive(1'b1, 1'b0, 32'(i));
    idle(3);
    for (int k = 0; k < 2; k++) expect_at(0, k, 1, 1'b0);
    for (int i = 0; i < 70; i++) drive(1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) expect_at(0, k, 0, 1'b0);

    // Streaming write+read every cycle: no bubbles once the head is valid.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b1, 32'(100 + i));
      if (i == 0)
        for (int j = 3; j <= 42; j++)
          for (int k = 0; k < 2; k++) expect_at(j, k, 0, 1'b1);
    end
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) expect_at(0, k, 0, 1'b0);

    // Consumer stalls for 10 cycles mid-stream.
    for (int i = 0; i < 30; i++) drive(1'b1, !(i >= 10 && i < 20), 32'(200 + i));
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 32'h0);

    // Random traffic.
    for (int i = 0; i < 10000; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    for (int i = 0; i < 80; i++) drive(1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) expect_at(0, k, 0, 1'b0);

    // Asynchronous reset with words in the BRAM and a read in flight.
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 32'(300 + i));
    drive(1'b0, 1'b1, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h3C);
    for (int k = 0; k < 2; k++) expect_at(3, k, 0, 1'b1);
    idle(3);
    drive(1'b0, 1'b1, 32'h0);
    idle(3);
    for (int k = 0; k < 2; k++) expect_at(0, k, 0, 1'b0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
